slc_config_loader: RTL and testbench

Loads configuration frames into one super logic cell (eight chained logic cells) and holds its flip-flops while it does so. A host streams 16-bit words over a valid/ready handshake. The block checks a header and an XOR checksum, then commits the per-cell mode, mux selects and LUT contents atomically to the cell. It also drives a hold signal that gates the cell's shared flip-flop enable for the whole load.

---
 rtl/slc_config_loader.sv | 141 ++++++++++++++
 tb/tb_slc_config_loader.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slc_config_loader.sv
// Configuration frame loader for one super logic cell: validates header and XOR checksum,
// then commits LUT contents, mode and mux selects atomically while holding the cell's flip-flops.
module slc_config_loader #(
    parameter int                NUM_LC   = 8,
    parameter int                WORD_W   = 16,
    parameter logic [WORD_W-1:0] HDR_WORD = 16'hA5C3
) (
    input  logic                     QCK,
    input  logic                     QRT,
    input  logic                     CFG_START,
    input  logic [WORD_W-1:0]        CFG_DATA,
    input  logic                     CFG_VALID,
    output logic                     CFG_READY,
    output logic [NUM_LC-1:0]        LC_MODE,
    output logic [NUM_LC-1:0]        LC_QDI_MUX,
    output logic [NUM_LC-1:0]        LC_BQZ_MUX,
    output logic [NUM_LC-1:0]        LC_CQZ_MUX,
    output logic [NUM_LC*WORD_W-1:0] LUT_INIT,
    output logic                     SLC_HOLD,
    output logic                     CFG_DONE,
    output logic                     CFG_ERR,
    output logic [2:0]               DBG_STATE
);

    localparam int NUM_SLOTS = NUM_LC + 2;
    localparam int CNT_W     = $clog2(NUM_SLOTS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_HDR    = 3'd1,
        S_BODY   = 3'd2,
        S_CHK    = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    state_t                     state_q;
    logic [CNT_W-1:0]           cnt_q;
    logic [WORD_W-1:0]          xor_q;
    logic [WORD_W-1:0]          xor_d;
    logic [WORD_W-1:0]          shadow_q [NUM_SLOTS];
    logic [NUM_LC-1:0]          mode_q;
    logic [NUM_LC-1:0]          qdi_q;
    logic [NUM_LC-1:0]          bqz_q;
    logic [NUM_LC-1:0]          cqz_q;
    logic [NUM_LC*WORD_W-1:0]   lut_q;
    logic                       hold_q;
    logic                       done_q;
    logic                       err_q;
    logic                       accept;

    // Handshake: a word transfers on a rising edge where CFG_VALID and CFG_READY are both high;
    // CFG_READY depends on the state register only, so the host may wait on it combinationally.
    assign CFG_READY = (state_q == S_HDR) || (state_q == S_BODY) || (state_q == S_CHK);
    assign accept    = CFG_VALID && CFG_READY;
    assign xor_d     = xor_q ^ CFG_DATA;

    always_ff @(posedge QCK) begin
        if (QRT) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            xor_q   <= '0;
            mode_q  <= '0;
            qdi_q   <= '0;
            bqz_q   <= '0;
            cqz_q   <= '0;
            lut_q   <= '0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (CFG_START) begin
            // START wins over any word on the same edge and over a pending commit.
            state_q <= S_HDR;
            cnt_q   <= '0;
            xor_q   <= '0;
            hold_q  <= 1'b1;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_HDR: begin
                    if (accept) begin
                        if (CFG_DATA == HDR_WORD) begin
                            state_q <= S_BODY;
                        end else begin
                            state_q <= S_IDLE;
                            err_q   <= 1'b1;
                            hold_q  <= 1'b0;
                        end
                    end
                end
                S_BODY: begin
                    if (accept) begin
                        shadow_q[cnt_q] <= CFG_DATA;
                        xor_q           <= xor_d;
                        cnt_q           <= cnt_q + 1'b1;
                        if (cnt_q == CNT_W'(NUM_SLOTS - 1)) begin
                            state_q <= S_CHK;
                        end
                    end
                end
                S_CHK: begin
                    if (accept) begin
                        if (CFG_DATA == xor_q) begin
                            state_q <= S_COMMIT;
                        end else begin
                            state_q <= S_IDLE;
                            err_q   <= 1'b1;
                            hold_q  <= 1'b0;
                        end
                    end
                end
                S_COMMIT: begin
                    for (int i = 0; i < NUM_LC; i++) begin
                        lut_q[i*WORD_W +: WORD_W] <= shadow_q[i];
                    end
                    mode_q  <= shadow_q[NUM_LC][NUM_LC-1:0];
                    qdi_q   <= shadow_q[NUM_LC][WORD_W-1:NUM_LC];
                    bqz_q   <= shadow_q[NUM_LC+1][NUM_LC-1:0];
                    cqz_q   <= shadow_q[NUM_LC+1][WORD_W-1:NUM_LC];
                    done_q  <= 1'b1;
                    hold_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign LC_MODE    = mode_q;
    assign LC_QDI_MUX = qdi_q;
    assign LC_BQZ_MUX = bqz_q;
    assign LC_CQZ_MUX = cqz_q;
    assign LUT_INIT   = lut_q;
    assign SLC_HOLD   = hold_q;
    assign CFG_DONE   = done_q;
    assign CFG_ERR    = err_q;
    assign DBG_STATE  = state_q;

endmodule

// File: tb/tb_slc_config_loader.sv
// Bench for slc_config_loader: random frames scored against a frame-level reference model.
module tb_slc_config_loader;

    localparam logic [15:0] HDR   = 16'hA5C3;
    localparam int          CFG_W = 160;
    localparam int          EXP_W = 162;

    logic         clk;
    logic         QRT;
    logic         CFG_START;
    logic [15:0]  CFG_DATA;
    logic         CFG_VALID;
    logic         CFG_READY;
    logic [7:0]   LC_MODE;
    logic [7:0]   LC_QDI_MUX;
    logic [7:0]   LC_BQZ_MUX;
    logic [7:0]   LC_CQZ_MUX;
    logic [127:0] LUT_INIT;
    logic         SLC_HOLD;
    logic         CFG_DONE;
    logic         CFG_ERR;
    logic [2:0]   DBG_STATE;

    slc_config_loader dut (
        .QCK        (clk),
        .QRT        (QRT),
        .CFG_START  (CFG_START),
        .CFG_DATA   (CFG_DATA),
        .CFG_VALID  (CFG_VALID),
        .CFG_READY  (CFG_READY),
        .LC_MODE    (LC_MODE),
        .LC_QDI_MUX (LC_QDI_MUX),
        .LC_BQZ_MUX (LC_BQZ_MUX),
        .LC_CQZ_MUX (LC_CQZ_MUX),
        .LUT_INIT   (LUT_INIT),
        .SLC_HOLD   (SLC_HOLD),
        .CFG_DONE   (CFG_DONE),
        .CFG_ERR    (CFG_ERR),
        .DBG_STATE  (DBG_STATE)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int acc_cnt   = 0;
    int hold_cnt  = 0;
    int ready_bad = 0;
    bit done_p    = 0;
    bit err_p     = 0;

    logic [EXP_W-1:0] exp_q [$];
    logic [15:0]      fw [12];
    logic [CFG_W-1:0] cur_cfg = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (CFG_VALID && CFG_READY) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string name, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [CFG_W-1:0] frame_cfg();
        logic [127:0] lut;
        for (int i = 0; i < 8; i++) lut[16*i +: 16] = fw[1+i];
        return {fw[10][15:8], fw[10][7:0], fw[9][15:8], fw[9][7:0], lut};
    endfunction

    function automatic logic [15:0] body_xor();
        logic [15:0] x = '0;
        for (int i = 1; i <= 10; i++) x ^= fw[i];
        return x;
    endfunction

    // Predicts the outcome of a frame that is sent to completion.
    task automatic model_frame();
        if (fw[0] != HDR || fw[11] != body_xor()) begin
            exp_q.push_back({1'b1, 1'b0, cur_cfg});
        end else begin
            cur_cfg = frame_cfg();
            exp_q.push_back({1'b0, 1'b1, cur_cfg});
        end
    endtask

    task automatic make_frame(input bit rnd);
        fw[0] = HDR;
        for (int i = 1; i <= 8; i++) fw[i] = rnd ? 16'($urandom) : 16'(i);
        fw[9]  = rnd ? 16'($urandom) : 16'hF00F;
        fw[10] = rnd ? 16'($urandom) : 16'h3CC3;
        fw[11] = body_xor();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (CFG_READY && (DBG_STATE == 3'd0 || DBG_STATE == 3'd4)) ready_bad++;
        if (SLC_HOLD) hold_cnt++;
        if ((CFG_DONE && !done_p) || (CFG_ERR && !err_p)) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result done=%0b err=%0b expected=no_event", CFG_DONE, CFG_ERR);
            end else begin
                chk("frame_result",
                    {CFG_ERR, CFG_DONE, LC_CQZ_MUX, LC_BQZ_MUX, LC_QDI_MUX, LC_MODE, LUT_INIT},
                    exp_q.pop_front());
            end
        end
        done_p = CFG_DONE;
        err_p  = CFG_ERR;
    end

    // ---------------- drivers (enter and leave at a falling edge) ----------------
    task automatic do_start();
        CFG_START = 1'b1;
        CFG_VALID = 1'b0;
        @(negedge clk);
        CFG_START = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d, input int gap_pct);
        bit ok = 0;
        bit acc;
        for (int t = 0; t < 200 && !ok; t++) begin
            if (int'($urandom_range(99)) < gap_pct) begin
                CFG_VALID = 1'b0;
                @(negedge clk);
            end else begin
                CFG_VALID = 1'b1;
                CFG_DATA  = d;
                acc       = CFG_READY;
                @(negedge clk);
                ok = acc;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_word_timeout actual=not_accepted expected=accepted data=%h", d);
        end
    endtask

    task automatic send_frame(input int n, input int gap_pct);
        for (int i = 0; i < n; i++) send_word(fw[i], gap_pct);
        CFG_VALID = 1'b0;
    endtask

    task automatic wait_result();
        int t = 0;
        while (exp_q.size() != 0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL result_timeout actual=pending%0d expected=0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset(input bit with_start);
        QRT       = 1'b1;
        CFG_START = with_start;
        CFG_VALID = 1'b1;
        CFG_DATA  = HDR;
        @(negedge clk);
        QRT       = 1'b0;
        CFG_START = 1'b0;
        CFG_VALID = 1'b0;
        cur_cfg   = '0;
        chk("reset_outputs",
            {CFG_READY, SLC_HOLD, CFG_DONE, CFG_ERR, LC_CQZ_MUX, LC_BQZ_MUX, LC_QDI_MUX, LC_MODE, LUT_INIT}, '0);
        chk("reset_state", DBG_STATE, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int start_cyc;
        int acc0;
        int t;
        QRT = 1'b1; CFG_START = 1'b0; CFG_VALID = 1'b0; CFG_DATA = '0;
        @(negedge clk);
        do_reset(0);

        // Good frame, valid held high: latency and hold window.
        make_frame(0);
        model_frame();
        hold_cnt = 0;
        do_start();
        start_cyc = cyc;
        send_frame(12, 0);
        t = 0;
        while (!CFG_DONE && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("done_edges", cyc - start_cyc + 1, 14);
        wait_result();
        chk("hold_cycles", hold_cnt, 13);
        chk("lut_cell0", LUT_INIT[15:0], 16'h0001);
        chk("lut_cell7", LUT_INIT[127:112], 16'h0008);
        chk("mode_mux", {LC_MODE, LC_QDI_MUX, LC_BQZ_MUX, LC_CQZ_MUX}, 32'h0FF0C33C);

        // Bad header: one word accepted, immediate error.
        fw[0] = 16'hA5C2;
        model_frame();
        acc0 = acc_cnt;
        do_start();
        send_word(fw[0], 0);
        chk("hdr_err_ready", CFG_READY, 0);
        chk("hdr_err_flag", {CFG_ERR, SLC_HOLD}, 2'b10);
        repeat (3) @(negedge clk);
        CFG_VALID = 1'b0;
        chk("hdr_err_accepts", acc_cnt - acc0, 1);
        wait_result();

        // Good frame, then checksum off by one keeps the first configuration.
        make_frame(1);
        model_frame();
        do_start();
        send_frame(12, 0);
        wait_result();
        make_frame(1);
        fw[11] ^= 16'h0001;
        model_frame();
        do_start();
        send_frame(12, 0);
        wait_result();

        // Fixed frame with ~50% valid gaps.
        make_frame(0);
        model_frame();
        acc0 = acc_cnt;
        do_start();
        send_frame(12, 50);
        wait_result();
        chk("gap_accepts", acc_cnt - acc0, 12);

        // Aborted partial frames, START coincident with a valid word.
        make_frame(1);
        do_start();
        send_frame(6, 30);
        do_start();
        send_frame(4, 0);
        CFG_START = 1'b1;
        CFG_VALID = 1'b1;
        CFG_DATA  = fw[4];
        @(negedge clk);
        CFG_START = 1'b0;
        CFG_VALID = 1'b0;
        make_frame(1);
        model_frame();
        send_frame(12, 20);
        wait_result();

        // Reset mid-BODY and coincident with START, then a normal load.
        make_frame(1);
        do_start();
        send_frame(5, 0);
        do_reset(0);
        do_start();
        send_frame(3, 0);
        do_reset(1);
        make_frame(1);
        model_frame();
        do_start();
        send_frame(12, 25);
        wait_result();

        // Random frames, some corrupted in header or checksum.
        for (int n = 0; n < 6; n++) begin
            make_frame(1);
            case ($urandom_range(3))
                0: fw[11] ^= 16'(1 << $urandom_range(15));
                1: fw[0]  ^= 16'(1 << $urandom_range(15));
                default: ;
            endcase
            model_frame();
            do_start();
            if (fw[0] != HDR) send_frame(1, 40);
            else send_frame(12, 40);
            wait_result();
        end

        chk("ready_idle_commit", ready_bad, 0);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
